// File: rtl/unidade_controle_if.sv
// Bus between the control unit and the rest of the 8-bit datapath:
// program memory read port, write-back mux select, register bank control,
// ALU operation, latched immediate, program counter and halt flag.
interface unidade_controle_if #(
    parameter int LARGURA = 8
);
    logic [LARGURA-1:0] dado_memoria;
    logic [LARGURA-1:0] endereco_memoria;
    logic [1:0]         controle_mux;
    logic [1:0]         op_ula;
    logic [1:0]         reg_destino;
    logic [1:0]         reg_fonte;
    logic               escreve_reg;
    logic [LARGURA-1:0] imediato;
    logic [LARGURA-1:0] pc;
    logic               parado;

    // Control unit side
    modport master (
        input  dado_memoria,
        output endereco_memoria,
        output controle_mux,
        output op_ula,
        output reg_destino,
        output reg_fonte,
        output escreve_reg,
        output imediato,
        output pc,
        output parado
    );

    // Datapath / memory side
    modport slave (
        output dado_memoria,
        input  endereco_memoria,
        input  controle_mux,
        input  op_ula,
        input  reg_destino,
        input  reg_fonte,
        input  escreve_reg,
        input  imediato,
        input  pc,
        input  parado
    );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle control unit for the 8-bit processor.
// Fetches an instruction byte, decodes it and sequences it through
// BUSCA -> DECODIFICA -> EXECUTA [-> IMEDIATO -> ESCRITA] -> BUSCA.
// Optional feature macro: UNIDADE_CONTROLE_SALTO_EN
//   defined   : opcode 110 is JMP (fetches a target byte, loads pc).
//   undefined : opcode 110 is a 3-cycle NOP.
module unidade_controle #(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset,
    unidade_controle_if.master bus
);

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        IMEDIATO   = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
    } estado_t;

    localparam logic [2:0] OP_LDI  = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    estado_t            estado;
    estado_t            prox_estado;
    logic [LARGURA-1:0] pc_q;
    logic [LARGURA-1:0] ir;
    logic [LARGURA-1:0] imediato_q;
    logic [2:0]         opcode;
    logic               escreve;
    logic [1:0]         mux_sel;
    logic [1:0]         op_sel;
    logic               ir_unused;

    assign opcode    = ir[7:5];
    assign ir_unused = ir[0];

    // State register plus the datapath registers loaded in specific states
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= BUSCA;
            pc_q       <= '0;
            ir         <= '0;
            imediato_q <= '0;
        end else begin
            estado <= prox_estado;
            case (estado)
                DECODIFICA: begin
                    ir   <= bus.dado_memoria;
                    pc_q <= pc_q + LARGURA'(1);
                end
                IMEDIATO: begin
                    imediato_q <= bus.dado_memoria;
                    pc_q       <= pc_q + LARGURA'(1);
                end
`ifdef UNIDADE_CONTROLE_SALTO_EN
                ESCRITA: begin
                    if (opcode == OP_JMP) begin
                        pc_q <= imediato_q;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and the write-cycle control outputs
    always_comb begin
        prox_estado = estado;
        escreve     = 1'b0;
        mux_sel     = 2'b00;
        op_sel      = 2'b00;
        case (estado)
            BUSCA:      prox_estado = DECODIFICA;
            DECODIFICA: prox_estado = EXECUTA;
            EXECUTA: begin
                case (opcode)
                    OP_LDI: prox_estado = IMEDIATO;
                    OP_MOV: begin
                        escreve     = 1'b1;
                        mux_sel     = 2'b01;
                        prox_estado = BUSCA;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        // opcode-2 modulo 4 needs only the low opcode bits
                        escreve     = 1'b1;
                        op_sel      = opcode[1:0] - 2'd2;
                        prox_estado = BUSCA;
                    end
`ifdef UNIDADE_CONTROLE_SALTO_EN
                    OP_JMP:  prox_estado = IMEDIATO;
`else
                    OP_JMP:  prox_estado = BUSCA;
`endif
                    OP_HALT: prox_estado = PARADO;
                    default: prox_estado = BUSCA;
                endcase
            end
            IMEDIATO: prox_estado = ESCRITA;
            ESCRITA: begin
                if (opcode == OP_LDI) begin
                    escreve = 1'b1;
                    mux_sel = 2'b10;
                end
                prox_estado = BUSCA;
            end
            PARADO:  prox_estado = PARADO;
            default: prox_estado = BUSCA;
        endcase
    end

    // A reset arriving during a write cycle suppresses the strobe so the
    // aborted instruction never reaches the register bank.
    assign bus.escreve_reg      = escreve & ~reset;
    assign bus.controle_mux     = mux_sel;
    assign bus.op_ula           = op_sel;
    assign bus.endereco_memoria = pc_q;
    assign bus.reg_destino      = ir[4:3];
    assign bus.reg_fonte        = ir[2:1];
    assign bus.imediato         = imediato_q;
    assign bus.pc               = pc_q;
    assign bus.parado           = (estado == PARADO);

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: an instruction-level model
// predicts, per instruction, its cycle count, write cycle, mux select,
// ALU operation, immediate and program counter progression.
module tb_unidade_controle;

`ifdef UNIDADE_CONTROLE_SALTO_EN
    localparam bit jmpEn = 1'b1;
`else
    localparam bit jmpEn = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic [7:0] mem [256];
    logic [7:0] modelPc;
    int         checkCount;
    int         passCount;
    int         failCount;
    bit         halted;

    unidade_controle_if #(.LARGURA(8)) bus ();

    unidade_controle #(.LARGURA(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous program memory: data appears the cycle after the address
    always @(posedge clock) begin
        bus.dado_memoria <= mem[bus.endereco_memoria];
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reset the DUT and check the post-reset outputs (sample point: cycle 1)
    task automatic resetDut();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst_pc", bus.pc, 8'h00);
        checkOutput("rst_addr", bus.endereco_memoria, 8'h00);
        checkOutput("rst_wr", bus.escreve_reg, 8'h00);
        checkOutput("rst_mux", bus.controle_mux, 8'h00);
        checkOutput("rst_op", bus.op_ula, 8'h00);
        checkOutput("rst_parado", bus.parado, 8'h00);
        checkOutput("rst_rd", bus.reg_destino, 8'h00);
        checkOutput("rst_rs", bus.reg_fonte, 8'h00);
        checkOutput("rst_imm", bus.imediato, 8'h00);
        modelPc = 8'h00;
    endtask

    // Run one instruction from modelPc, checking every cycle of it
    task automatic applyStimulus(output bit isHalt);
        logic [7:0] b, p, p1, p2, nextPc, expPc;
        int         opc, len, wrCycle;
        logic [1:0] muxExp, opExp;
        bit         hasImm;
        p   = modelPc;
        p1  = p + 8'd1;
        p2  = p + 8'd2;
        b   = mem[p];
        opc = int'(b[7:5]);
        hasImm  = (opc == 0) || (opc == 6 && jmpEn);
        len     = hasImm ? 5 : 3;
        wrCycle = (opc >= 1 && opc <= 5) ? 3 : ((opc == 0) ? 5 : 0);
        muxExp  = (opc == 1) ? 2'b01 : ((opc == 0) ? 2'b10 : 2'b00);
        opExp   = (opc >= 2 && opc <= 5) ? 2'(opc - 2) : 2'b00;
        if (opc == 0)               nextPc = p2;
        else if (opc == 6 && jmpEn) nextPc = mem[p1];
        else                        nextPc = p1;
        for (int c = 1; c <= len; c++) begin
            expPc = (c <= 2) ? p : ((c <= 4) ? p1 : p2);
            checkOutput("pc", bus.pc, expPc);
            checkOutput("addr", bus.endereco_memoria, expPc);
            checkOutput("wr", bus.escreve_reg, (c == wrCycle) ? 8'h01 : 8'h00);
            checkOutput("mux", bus.controle_mux, (c == wrCycle) ? 8'(muxExp) : 8'h00);
            checkOutput("parado", bus.parado, 8'h00);
            if (c >= 3) begin
                checkOutput("rd", bus.reg_destino, 8'(b[4:3]));
                checkOutput("rs", bus.reg_fonte, 8'(b[2:1]));
            end
            if (c == 3) checkOutput("op_ula", bus.op_ula, 8'(opExp));
            if (c == 5) checkOutput("imm", bus.imediato, mem[p1]);
            @(negedge clock);
        end
        isHalt  = (opc == 7);
        modelPc = nextPc;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        reset      = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h20;

        // Directed program: LDI r2,55; MOV r1,r3; SUB r0,r1; OR; JMP FE; HALT
        mem[0] = 8'h10; mem[1] = 8'h55; mem[2] = 8'h2E; mem[3] = 8'h62;
        mem[4] = 8'hA0; mem[5] = 8'hC0; mem[6] = 8'hFE; mem[7] = 8'hE0;
        mem[8'hFE] = 8'h2E; mem[8'hFF] = 8'h00;
        resetDut();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(halted);
            if (halted) break;
        end

        // HALT: parado held with no write strobe until reset
        mem[0] = 8'hE0;
        resetDut();
        applyStimulus(halted);
        for (int i = 0; i < 22; i++) begin
            checkOutput("halt_parado", bus.parado, 8'h01);
            checkOutput("halt_wr", bus.escreve_reg, 8'h00);
            checkOutput("halt_pc", bus.pc, 8'h01);
            @(negedge clock);
        end
        resetDut();

        // Reset during the ESCRITA cycle of an LDI aborts the write
        mem[0] = 8'h18; mem[1] = 8'hA5;
        resetDut();
        repeat (4) @(negedge clock);
        checkOutput("abort_pre_wr", bus.escreve_reg, 8'h01);
        reset = 1'b1;
        #1;
        checkOutput("abort_wr", bus.escreve_reg, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("abort_pc", bus.pc, 8'h00);
        checkOutput("abort_imm", bus.imediato, 8'h00);
        checkOutput("abort_wr_after", bus.escreve_reg, 8'h00);
        modelPc = 8'h00;
        applyStimulus(halted);

        // Randomized program with no HALT bytes
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom_range(0, 255));
            if (mem[i][7:5] == 3'b111) mem[i][7:5] = 3'($urandom_range(0, 6));
        end
        resetDut();
        for (int i = 0; i < 150; i++) applyStimulus(halted);

        // Straight-line MOV/ALU code long enough to wrap pc past FF
        for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(1, 5)), 5'($urandom)};
        resetDut();
        for (int i = 0; i < 260; i++) applyStimulus(halted);
        checkOutput("wrap_pc", bus.pc, 8'd4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the 8-bit processor datapath. It fetches and decodes instruction bytes from program memory, sequences each instruction through a fixed state machine, and drives the 2-bit select of the 3-input 8-bit write-back multiplexer. It also drives the register-bank write strobe, the register addresses, the ALU operation and the immediate byte. It sits directly upstream of the write-back mux: `controle_mux` feeds the mux `Controle` input and `imediato` feeds `Entrada2`.

## Interface
Parameters:
- `LARGURA`, 8, data/address width; the block is only specified for 8.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dado_memoria` in 8: program memory read data, valid in the cycle after `endereco_memoria` is presented.
- `endereco_memoria` out 8: program memory address.
- `controle_mux` out 2: write-back mux select. 00 selects the ALU result (`Entrada0`), 01 selects the rs register value (`Entrada1`), 10 selects `imediato` (`Entrada2`). The block never drives 11.
- `op_ula` out 2: ALU operation. 00 ADD, 01 SUB, 10 AND, 11 OR.
- `reg_destino` out 2: rd, taken from `ir[4:3]`.
- `reg_fonte` out 2: rs, taken from `ir[2:1]`.
- `escreve_reg` out 1: register-bank write strobe, one cycle wide.
- `imediato` out 8: latched immediate byte.
- `pc` out 8: program counter.
- `parado` out 1: high while in PARADO.

## Operation
- Instruction format: `ir[7:5]` opcode, `ir[4:3]` rd, `ir[2:1]` rs, `ir[0]` ignored.
- Opcodes:
  - 000 LDI: rd ← next byte.
  - 001 MOV: rd ← rs.
  - 010 ADD, 011 SUB, 100 AND, 101 OR: rd ← rd op rs.
  - 110 JMP: pc ← next byte.
  - 111 HALT.
- States:
  - BUSCA: `endereco_memoria = pc`; go to DECODIFICA.
  - DECODIFICA: `ir ← dado_memoria`; `pc ← pc+1`; go to EXECUTA.
  - EXECUTA, MOV/ALU ops: `escreve_reg = 1`. `controle_mux` is 01 for MOV and 00 for ALU ops. `op_ula` is `opcode - 2` for ALU ops and 00 otherwise. Go to BUSCA.
  - EXECUTA, LDI/JMP: `endereco_memoria = pc`; go to IMEDIATO.
  - EXECUTA, HALT: go to PARADO.
  - IMEDIATO: `imediato ← dado_memoria`; `pc ← pc+1`; go to ESCRITA.
  - ESCRITA, LDI: `escreve_reg = 1`, `controle_mux = 10`; go to BUSCA.
  - ESCRITA, JMP: `pc ← imediato`; go to BUSCA.
  - PARADO: `parado = 1`; held until reset.
- Output defaults: outside the write cycles listed above, `escreve_reg = 0` and `controle_mux = 00`. In all other states, `endereco_memoria` holds `pc`.
- Reset (sampled at a rising edge) sets: state BUSCA, `pc = 0`, `ir = 0`, `imediato = 0`. Combinational outputs then read: `escreve_reg = 0`, `controle_mux = 00`, `op_ula = 00`, `parado = 0`, `endereco_memoria = 0`, `reg_destino = reg_fonte = 0`.
- Reset asserted mid-instruction aborts the instruction. No write strobe is issued for it.
- `pc` arithmetic is modulo 256: FF+1 = 00. This applies to both opcode fetch and immediate fetch at FF.
- `ir[0]` has no effect on any output.

## Timing
- Cycle counts:
  - MOV and ALU ops: 3 cycles (BUSCA, DECODIFICA, EXECUTA).
  - LDI and JMP: 5 cycles.
  - HALT: 3 cycles to reach PARADO.
- `escreve_reg` and `controle_mux` are combinational from state and `ir`. They are stable for the whole write cycle; the register bank samples at the end of that cycle.
- `controle_mux` is valid in the same cycle as `escreve_reg`. There is no pipelining and there is one outstanding memory read at most.
- A new `pc` value is visible in the cycle after DECODIFICA, IMEDIATO or JMP-ESCRITA.

## Configuration
- Macro: `UNIDADE_CONTROLE_SALTO_EN`.
- Defined: JMP is implemented as described above.
- Undefined: opcode 110 executes as a 3-cycle NOP with no immediate fetch, no write, and `pc` advanced by 1 only.
- All other opcodes behave identically in both builds.

## Test plan
- Reset then LDI r2,0x55 (bytes 0x10, 0x55): in cycle 5, `escreve_reg=1`, `controle_mux=10`, `reg_destino=2`, `imediato=0x55`; `pc=2` afterwards.
- MOV r1,r3 (0x2E): in cycle 3, `escreve_reg=1`, `controle_mux=01`, `reg_destino=1`, `reg_fonte=3`; 3-cycle instruction.
- SUB r0,r1 (0x62): `controle_mux=00`, `op_ula=01`, one write strobe. OR (0xA0) gives `op_ula=11`.
- JMP 0xFE (with the macro defined): `pc=0xFE` after ESCRITA. Next fetch at FE, then `pc` wraps to 00 after a fetch at FF. Without the macro, `pc` advances by 1 and no write occurs.
- HALT (0xE0): `parado=1` from cycle 4 and held for 20+ cycles with `escreve_reg=0`. Reset returns to BUSCA with `pc=0`.
- Reset asserted in the ESCRITA cycle of an LDI: no `escreve_reg` pulse, state BUSCA, `pc=0` on the next cycle.
